// File: rtl/gb_bank_ring_ptr.sv
// Per-channel bank ring pointers for the global buffer SRAM groups.
// Each channel tracks its write/read bank IDs and fill count, with sticky error on illegal pulses.
module gb_bank_ring_ptr #(
  parameter int NCH = 4,
  parameter int IDW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 CFG_load,
  input  logic [3:0]           CFGGB_SRAM_num_wei,
  input  logic [3:0]           CFGGB_SRAM_num_flgwei,
  input  logic [3:0]           CFGGB_SRAM_num_act,
  input  logic [3:0]           CFGGB_SRAM_num_flgact,
  input  logic [NCH-1:0]       wr_done,
  input  logic [NCH-1:0]       rd_done,
  output logic [NCH*IDW-1:0]   wr_cor_ID,
  output logic [NCH*IDW-1:0]   rd_cor_ID,
  output logic [NCH-1:0]       full,
  output logic [NCH-1:0]       empty,
  output logic [NCH-1:0]       err
);

  logic [IDW-1:0] numQ_r  [NCH];
  logic [IDW-1:0] wrPtr_r [NCH];
  logic [IDW-1:0] rdPtr_r [NCH];
  logic [IDW-1:0] cnt_r   [NCH];
  logic [NCH-1:0] err_r;
  logic [IDW-1:0] cfgNum_s [NCH];
  logic [NCH-1:0] full_s;
  logic [NCH-1:0] empty_s;
  logic [NCH-1:0] wrAcc_s;
  logic [NCH-1:0] rdAcc_s;

  // Ring advance wraps at the configured bank count, not at the ID width.
  function automatic logic [IDW-1:0] nextPtr(input logic [IDW-1:0] ptr, input logic [IDW-1:0] num);
    logic [IDW-1:0] nxt;
    if (ptr == (num - {{(IDW-1){1'b0}}, 1'b1})) begin
      nxt = {IDW{1'b0}};
    end else begin
      nxt = ptr + {{(IDW-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  assign cfgNum_s[0] = CFGGB_SRAM_num_wei;
  assign cfgNum_s[1] = CFGGB_SRAM_num_flgwei;
  assign cfgNum_s[2] = CFGGB_SRAM_num_act;
  assign cfgNum_s[3] = CFGGB_SRAM_num_flgact;

  // Flag decode and acceptance from registered state only.
  always_comb begin
    full_s    = '0;
    empty_s   = '0;
    wrAcc_s   = '0;
    rdAcc_s   = '0;
    wr_cor_ID = '0;
    rd_cor_ID = '0;
    for (int i = 0; i < NCH; i++) begin
      full_s[i]  = (cnt_r[i] == numQ_r[i]);
      empty_s[i] = (cnt_r[i] == {IDW{1'b0}});
      wrAcc_s[i] = wr_done[i] & ~full_s[i];
      rdAcc_s[i] = rd_done[i] & ~empty_s[i];
      wr_cor_ID[i*IDW +: IDW] = wrPtr_r[i];
      rd_cor_ID[i*IDW +: IDW] = rdPtr_r[i];
    end
  end

  assign full  = full_s;
  assign empty = empty_s;
  assign err   = err_r;

  // Ring state: reset, configuration load, then per-channel pointer/count updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        numQ_r[i]  <= {IDW{1'b0}};
        wrPtr_r[i] <= {IDW{1'b0}};
        rdPtr_r[i] <= {IDW{1'b0}};
        cnt_r[i]   <= {IDW{1'b0}};
      end
      err_r <= '0;
    end else if (CFG_load) begin
      for (int i = 0; i < NCH; i++) begin
        numQ_r[i]  <= cfgNum_s[i];
        wrPtr_r[i] <= {IDW{1'b0}};
        rdPtr_r[i] <= {IDW{1'b0}};
        cnt_r[i]   <= {IDW{1'b0}};
      end
      err_r <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wrAcc_s[i]) begin
          wrPtr_r[i] <= nextPtr(wrPtr_r[i], numQ_r[i]);
        end else begin
          wrPtr_r[i] <= wrPtr_r[i];
        end
        if (rdAcc_s[i]) begin
          rdPtr_r[i] <= nextPtr(rdPtr_r[i], numQ_r[i]);
        end else begin
          rdPtr_r[i] <= rdPtr_r[i];
        end
        case ({wrAcc_s[i], rdAcc_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + {{(IDW-1){1'b0}}, 1'b1};
          2'b01:   cnt_r[i] <= cnt_r[i] - {{(IDW-1){1'b0}}, 1'b1};
          default: cnt_r[i] <= cnt_r[i];
        endcase
        numQ_r[i] <= numQ_r[i];
      end
      // Rejected pulses (full write, empty read, disabled channel) latch the error.
      err_r <= err_r | (wr_done & full_s) | (rd_done & empty_s);
    end
  end

endmodule

// File: tb/tb_gb_bank_ring_ptr.sv
// Directed self-checking bench for gb_bank_ring_ptr.
// Each scenario task drives pulses and compares outputs against hand-computed values.
module tb_gb_bank_ring_ptr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CFG_load;
  logic [3:0]  numWei, numFlgwei, numAct, numFlgact;
  logic [3:0]  wr_done, rd_done;
  logic [15:0] wr_cor_ID, rd_cor_ID;
  logic [3:0]  full, empty, err;
  int          nTests = 0;
  int          nFail  = 0;

  always #5 clk = ~clk;

  gb_bank_ring_ptr #(.NCH(4), .IDW(4)) dut (
    .clk(clk), .rst_n(rst_n), .CFG_load(CFG_load),
    .CFGGB_SRAM_num_wei(numWei), .CFGGB_SRAM_num_flgwei(numFlgwei),
    .CFGGB_SRAM_num_act(numAct), .CFGGB_SRAM_num_flgact(numFlgact),
    .wr_done(wr_done), .rd_done(rd_done),
    .wr_cor_ID(wr_cor_ID), .rd_cor_ID(rd_cor_ID),
    .full(full), .empty(empty), .err(err)
  );

  task automatic tick(input logic [3:0] w, input logic [3:0] r);
    wr_done = w;
    rd_done = r;
    @(posedge clk);
    #1;
    wr_done = 4'h0;
    rd_done = 4'h0;
  endtask

  task automatic cfg(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                     input logic [3:0] d, input logic [3:0] w);
    numWei = a; numFlgwei = b; numAct = c; numFlgact = d;
    CFG_load = 1'b1;
    tick(w, 4'h0);
    CFG_load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(4'h0, 4'h0);
    rst_n = 1'b1;
    nTests++; if (wr_cor_ID !== 16'h0000) begin nFail++; $display("FAIL reset_wrid got %h exp 0000", wr_cor_ID); end
    nTests++; if (rd_cor_ID !== 16'h0000) begin nFail++; $display("FAIL reset_rdid got %h exp 0000", rd_cor_ID); end
    nTests++; if (full !== 4'hF) begin nFail++; $display("FAIL reset_full got %h exp F", full); end
    nTests++; if (empty !== 4'hF) begin nFail++; $display("FAIL reset_empty got %h exp F", empty); end
    nTests++; if (err !== 4'h0) begin nFail++; $display("FAIL reset_err got %h exp 0", err); end
  endtask

  task automatic test_cfg;
    cfg(4'd3, 4'd2, 4'd4, 4'd1, 4'h0);
    nTests++; if (empty !== 4'hF) begin nFail++; $display("FAIL cfg_empty got %h exp F", empty); end
    nTests++; if (full !== 4'h0) begin nFail++; $display("FAIL cfg_full got %h exp 0", full); end
    nTests++; if ({wr_cor_ID, rd_cor_ID} !== 32'h0) begin nFail++; $display("FAIL cfg_ids got %h/%h exp 0", wr_cor_ID, rd_cor_ID); end
    nTests++; if (err !== 4'h0) begin nFail++; $display("FAIL cfg_err got %h exp 0", err); end
  endtask

  task automatic test_wei_fill;
    logic [3:0] expId [3];
    expId = '{4'd1, 4'd2, 4'd0};
    for (int i = 0; i < 3; i++) begin
      tick(4'b0001, 4'h0);
      nTests++; if (wr_cor_ID[3:0] !== expId[i]) begin nFail++; $display("FAIL wei_wrid step %0d got %0d exp %0d", i, wr_cor_ID[3:0], expId[i]); end
    end
    nTests++; if (full[0] !== 1'b1 || empty[0] !== 1'b0) begin nFail++; $display("FAIL wei_full got full=%b empty=%b exp 1/0", full[0], empty[0]); end
    tick(4'b0001, 4'h0);
    nTests++; if (err !== 4'b0001) begin nFail++; $display("FAIL wei_overflow_err got %b exp 0001", err); end
    nTests++; if (wr_cor_ID[3:0] !== 4'd0) begin nFail++; $display("FAIL wei_overflow_id got %0d exp 0", wr_cor_ID[3:0]); end
  endtask

  task automatic test_act_wrap;
    logic [3:0] expRd [6];
    logic [3:0] expWr [6];
    expRd = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2};
    expWr = '{4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    tick(4'b0100, 4'h0);
    tick(4'b0100, 4'h0);
    nTests++; if (wr_cor_ID[11:8] !== 4'd2) begin nFail++; $display("FAIL act_fill_id got %0d exp 2", wr_cor_ID[11:8]); end
    for (int i = 0; i < 6; i++) begin
      tick(4'b0100, 4'b0100);
      nTests++; if (rd_cor_ID[11:8] !== expRd[i] || wr_cor_ID[11:8] !== expWr[i]) begin
        nFail++; $display("FAIL act_wrap step %0d got rd=%0d wr=%0d exp rd=%0d wr=%0d", i, rd_cor_ID[11:8], wr_cor_ID[11:8], expRd[i], expWr[i]);
      end
      nTests++; if (full[2] !== 1'b0 || empty[2] !== 1'b0) begin nFail++; $display("FAIL act_cnt step %0d got full=%b empty=%b exp 0/0", i, full[2], empty[2]); end
    end
    nTests++; if (err[2] !== 1'b0) begin nFail++; $display("FAIL act_err got %b exp 0", err[2]); end
  endtask

  task automatic test_flgact;
    tick(4'b1000, 4'h0);
    nTests++; if (full[3] !== 1'b1 || empty[3] !== 1'b0) begin nFail++; $display("FAIL flgact_fill got full=%b empty=%b exp 1/0", full[3], empty[3]); end
    tick(4'b1000, 4'b1000);
    nTests++; if (err[3] !== 1'b1) begin nFail++; $display("FAIL flgact_err got %b exp 1", err[3]); end
    nTests++; if (empty[3] !== 1'b1 || full[3] !== 1'b0) begin nFail++; $display("FAIL flgact_drain got full=%b empty=%b exp 0/1", full[3], empty[3]); end
    nTests++; if (rd_cor_ID[15:12] !== 4'd0 || wr_cor_ID[15:12] !== 4'd0) begin nFail++; $display("FAIL flgact_ids got rd=%0d wr=%0d exp 0/0", rd_cor_ID[15:12], wr_cor_ID[15:12]); end
  endtask

  task automatic test_flgwei;
    tick(4'h0, 4'b0010);
    nTests++; if (err !== 4'b1011) begin nFail++; $display("FAIL flgwei_underflow_err got %b exp 1011", err); end
    nTests++; if (rd_cor_ID[7:4] !== 4'd0) begin nFail++; $display("FAIL flgwei_rdid got %0d exp 0", rd_cor_ID[7:4]); end
    cfg(4'd3, 4'd0, 4'd4, 4'd1, 4'h0);
    nTests++; if (err !== 4'h0) begin nFail++; $display("FAIL flgwei_cfg_err got %b exp 0000", err); end
    nTests++; if (full !== 4'b0010 || empty !== 4'hF) begin nFail++; $display("FAIL flgwei_disabled got full=%b empty=%b exp 0010/1111", full, empty); end
    tick(4'b0010, 4'h0);
    nTests++; if (err !== 4'b0010 || wr_cor_ID[7:4] !== 4'd0) begin nFail++; $display("FAIL flgwei_disabled_wr got err=%b id=%0d exp 0010/0", err, wr_cor_ID[7:4]); end
  endtask

  task automatic test_rst_mid;
    cfg(4'd3, 4'd2, 4'd4, 4'd1, 4'h0);
    tick(4'b0001, 4'h0);
    tick(4'b0001, 4'h0);
    nTests++; if (wr_cor_ID[3:0] !== 4'd2 || empty[0] !== 1'b0) begin nFail++; $display("FAIL mid_fill got id=%0d empty=%b exp 2/0", wr_cor_ID[3:0], empty[0]); end
    rst_n = 1'b0;
    tick(4'h0, 4'h0);
    rst_n = 1'b1;
    nTests++; if ({wr_cor_ID, rd_cor_ID} !== 32'h0) begin nFail++; $display("FAIL mid_rst_ids got %h/%h exp 0", wr_cor_ID, rd_cor_ID); end
    nTests++; if (full !== 4'hF || empty !== 4'hF) begin nFail++; $display("FAIL mid_rst_flags got full=%h empty=%h exp F/F", full, empty); end
    cfg(4'd3, 4'd2, 4'd4, 4'd1, 4'b0001);
    nTests++; if (wr_cor_ID[3:0] !== 4'd0 || empty[0] !== 1'b1 || err !== 4'h0) begin
      nFail++; $display("FAIL cfg_prio got id=%0d empty=%b err=%b exp 0/1/0000", wr_cor_ID[3:0], empty[0], err);
    end
    tick(4'b0001, 4'h0);
    nTests++; if (wr_cor_ID[3:0] !== 4'd1 || empty[0] !== 1'b0) begin nFail++; $display("FAIL post_cfg_wr got id=%0d empty=%b exp 1/0", wr_cor_ID[3:0], empty[0]); end
  endtask

  initial begin
    rst_n = 1'b0; CFG_load = 1'b0; wr_done = 4'h0; rd_done = 4'h0;
    numWei = 4'h0; numFlgwei = 4'h0; numAct = 4'h0; numFlgact = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_cfg;
    test_wei_fill;
    test_act_wrap;
    test_flgact;
    test_flgwei;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/gb_bank_ring_ptr.md
Name: gb_bank_ring_ptr

Overview:
- Tracks bank occupancy in the global buffer (GB) as four independent ring buffers, one per SRAM group: weight, weight-flag, activation and activation-flag.
- Produces the relative (corrected) bank IDs consumed directly downstream by the relative-to-absolute bank-ID translator.
- Each bank is an element of its ring. Producers mark a bank filled; consumers mark a bank drained.

Parameters:
- NCH, 4, number of channels (fixed channel index: 0=wei, 1=flgwei, 2=act, 3=flgact)
- IDW, 4, relative bank-ID width; banks per channel range 0..15

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- CFG_load  input  1  one-cycle strobe; latch bank counts and clear all ring state
- CFGGB_SRAM_num_wei  input  4  banks in weight group
- CFGGB_SRAM_num_flgwei  input  4  banks in weight-flag group
- CFGGB_SRAM_num_act  input  4  banks in activation group
- CFGGB_SRAM_num_flgact  input  4  banks in activation-flag group
- wr_done  input  NCH  per-channel pulse: producer finished filling current write bank
- rd_done  input  NCH  per-channel pulse: consumer finished draining current read bank
- wr_cor_ID  output  NCH*IDW  packed per-channel write-bank relative ID, ch0 in [3:0]
- rd_cor_ID  output  NCH*IDW  packed per-channel read-bank relative ID, ch0 in [3:0]
- full  output  NCH  channel has no free bank
- empty  output  NCH  channel has no filled bank
- err  output  NCH  sticky: illegal wr_done or rd_done seen on channel

Behaviour:
- Reset (rst_n=0 at posedge):
  - Clears num_q, wr_ptr, rd_ptr, cnt and err to 0.
  - Outputs after reset: wr_cor_ID=0, rd_cor_ID=0, err=0, full=4'hF, empty=4'hF.
  - Reset mid-operation discards all occupancy.
- Per-channel state: num_q[3:0], wr_ptr[3:0], rd_ptr[3:0], cnt[3:0].
- CFG_load=1 at posedge:
  - num_q <= CFG inputs.
  - wr_ptr, rd_ptr, cnt and err cleared.
  - wr_done and rd_done are ignored in that cycle; CFG_load has priority.
- Disabled channel (num_q==0):
  - full=1, empty=1.
  - Any wr_done or rd_done on that channel sets err; state unchanged.
- Flag decode, combinational from registers only:
  - full = (cnt==num_q)
  - empty = (cnt==0)
  - Flags reflect an event the cycle after the event edge (1-cycle latency).
- Acceptance, using pre-edge state:
  - wr_acc = wr_done & ~full
  - rd_acc = rd_done & ~empty
  - wr_done while full sets err; wr_ptr and cnt unchanged.
  - rd_done while empty sets err; rd_ptr and cnt unchanged.
- Pointer update on acceptance: ptr <= (ptr==num_q-1) ? 0 : ptr+1. Wrap is at num_q-1, not at 15.
- Count update:
  - cnt +1 on wr_acc only.
  - cnt -1 on rd_acc only.
  - cnt unchanged when both are accepted.
- Simultaneous wr_done and rd_done:
  - Channel full: rd accepted, wr rejected, err set.
  - Channel empty: wr accepted, rd rejected, err set.
- Outputs wr_cor_ID and rd_cor_ID are direct register outputs (wr_ptr, rd_ptr); no combinational path from inputs.
- Channels are fully independent; no cross-channel interaction except the shared CFG_load.
- err is cleared only by reset or CFG_load.
- Invariants verification must check:
  - cnt <= num_q
  - (wr_ptr - rd_ptr) mod num_q == cnt mod num_q

Test Plan:
- Reset, then CFG_load with num={wei=3, flgwei=2, act=4, flgact=1} -> all empty=1, full=0, all IDs 0, err=0.
- wei: 3 wr_done pulses -> wr_cor_ID[3:0] goes 1,2,0; full[0]=1 after third; a 4th wr_done -> err[0]=1, wr_cor_ID stays 0.
- act (num 4): fill 2 banks, then assert wr_done and rd_done together for 6 cycles -> cnt stays 2; rd_cor_ID[11:8] runs 1,2,3,0,1,2; pointers wrap at 3.
- flgact (num 1): wr_done -> full[3]=1, empty[3]=1→0; next cycle assert wr_done and rd_done together -> rd accepted, wr rejected, err[3]=1, empty[3]=1.
- flgwei: rd_done while empty -> err[1]=1, rd_cor_ID unchanged. Then CFG_load with num_flgwei=0 -> err cleared, full[1]=empty[1]=1; wr_done -> err[1]=1.
- Mid-fill wei (cnt=2): pulse rst_n=0 for one cycle -> next cycle all IDs 0, full=empty=4'hF. A CFG_load in the same cycle as wr_done -> wr_done ignored, cnt=0.
